uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UartTx instance between NUM_REQ byte producers, such as the loopback path, a status reporter and a debug source. It owns the transmitter's write_i and data_i. Each write is sequenced by observing busy_o: start, then completion. A stall watchdog recovers the arbiter if the transmitter never acknowledges a write.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares a single UartTx between NUM_REQ byte producers using round-robin
//   arbitration. The arbiter owns the transmitter's write/data inputs and
//   sequences every write by watching busy: first busy must rise (start),
//   then it must fall (completion). If busy never rises after a write, a
//   watchdog abandons the write so the arbiter cannot lock up.
//
// Ports:
//   clock_i        system clock, everything on the rising edge
//   reset_i        synchronous, active-high reset
//   req_valid_i    per-requester "byte pending" flags, held until acked
//   req_data_i     byte of requester k at bits [8k+7:8k]
//   req_ack_o      one-cycle pulse, byte of requester k has been captured
//   tx_write_o     one-cycle write strobe to UartTx
//   tx_data_o      byte to UartTx, stable from grant until back in IDLE
//   tx_busy_i      busy flag from UartTx
//   grant_o        one-hot current owner, zero when idle
//   grant_index_o  binary index of the last/current owner
//   active_o       high whenever the arbiter is not idle
//   timeout_o      one-cycle pulse when a write is abandoned
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int IDX_WIDTH     = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ack_o,
  output logic                   tx_write_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_busy_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [IDX_WIDTH-1:0]   grant_index_o,
  output logic                   active_o,
  output logic                   timeout_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]               r_state;
  logic [NUM_REQ-1:0]       r_ack;
  logic                     r_write;
  logic [7:0]               r_data;
  logic [NUM_REQ-1:0]       r_grant;
  logic [IDX_WIDTH-1:0]     r_grantIndex;
  logic [IDX_WIDTH-1:0]     r_lastGrant;
  logic                     r_active;
  logic                     r_timeout;
  logic [TIMEOUT_WIDTH-1:0] r_count;

  logic                     w_found;
  logic [IDX_WIDTH-1:0]     w_winIdx;
  logic [7:0]               w_winData;

  // Round-robin winner search. The first pass picks the lowest valid index
  // overall, which is the answer when the search has to wrap around. The
  // second pass overrides it with the lowest valid index strictly above the
  // last grant, if one exists. Both loops run downward so that the final
  // assignment in each pass is the lowest qualifying index.
  always_comb begin
    w_found   = 1'b0;
    w_winIdx  = '0;
    w_winData = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        w_found   = 1'b1;
        w_winIdx  = IDX_WIDTH'(k);
        w_winData = req_data_i[8*k +: 8];
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (k > int'(r_lastGrant))) begin
        w_found   = 1'b1;
        w_winIdx  = IDX_WIDTH'(k);
        w_winData = req_data_i[8*k +: 8];
      end
    end
  end

  // Main sequencer. Strobes (ack, write, timeout) default low every cycle so
  // they are single-cycle pulses. tx_data and grant_index are left untouched
  // on the way back to IDLE so they keep describing the last transfer.
  // last_grant resets to NUM_REQ-1 so requester 0 is favoured first.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_ack        <= '0;
      r_write      <= 1'b0;
      r_data       <= '0;
      r_grant      <= '0;
      r_grantIndex <= '0;
      r_lastGrant  <= IDX_WIDTH'(NUM_REQ - 1);
      r_active     <= 1'b0;
      r_timeout    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_ack     <= '0;
      r_write   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !tx_busy_i) begin
            r_state      <= ST_WRITE;
            r_write      <= 1'b1;
            r_data       <= w_winData;
            r_ack        <= NUM_REQ'(1) << w_winIdx;
            r_grant      <= NUM_REQ'(1) << w_winIdx;
            r_grantIndex <= w_winIdx;
            r_lastGrant  <= w_winIdx;
            r_active     <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state <= ST_WAIT_BUSY;
          r_count <= '0;
        end
        ST_WAIT_BUSY: begin
          // A transmitter that never raises busy would stall us forever;
          // after START_TIMEOUT quiet cycles the byte is dropped. It is not
          // re-requested because the requester was already acked.
          if (tx_busy_i) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_count == TIMEOUT_WIDTH'(START_TIMEOUT - 1)) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_grant   <= '0;
            r_active  <= 1'b0;
          end else begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o     = r_ack;
  assign tx_write_o    = r_write;
  assign tx_data_o     = r_data;
  assign grant_o       = r_grant;
  assign grant_index_o = r_grantIndex;
  assign active_o      = r_active;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Purpose:
//   Self-checking bench for uart_tx_arbiter. A four-requester instance is
//   exercised with a table of per-cycle vectors followed by hand-written
//   multi-cycle sequences (exact single write, fairness, watchdog, reset in
//   the middle of a frame). A one-requester instance checks the degenerate
//   build. Inputs are applied just after a rising edge and outputs are
//   sampled 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  eAck;
    logic        eWrite;
    logic [7:0]  eData;
    logic [3:0]  eGrant;
    logic [1:0]  eIdx;
    logic        eActive;
    logic        eTimeout;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic        txBusy;
  logic [3:0]  reqAck;
  logic        txWrite;
  logic [7:0]  txData;
  logic [3:0]  grant;
  logic [1:0]  grantIndex;
  logic        active;
  logic        timeout;

  logic        reqValid1;
  logic [7:0]  reqData1;
  logic        txBusy1;
  logic        reqAck1;
  logic        txWrite1;
  logic [7:0]  txData1;
  logic        grant1;
  logic        grantIndex1;
  logic        active1;
  logic        timeout1;

  int          checkCount;
  int          passCount;
  int          writeCount;
  vec_t        vecs [13];

  uart_tx_arbiter #(
    .NUM_REQ(4), .START_TIMEOUT(16), .TIMEOUT_WIDTH(8), .IDX_WIDTH(2)
  ) dut (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(reqValid), .req_data_i(reqData), .req_ack_o(reqAck),
    .tx_write_o(txWrite), .tx_data_o(txData), .tx_busy_i(txBusy),
    .grant_o(grant), .grant_index_o(grantIndex),
    .active_o(active), .timeout_o(timeout)
  );

  uart_tx_arbiter #(
    .NUM_REQ(1), .START_TIMEOUT(16), .TIMEOUT_WIDTH(8), .IDX_WIDTH(1)
  ) dutSingle (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(reqValid1), .req_data_i(reqData1), .req_ack_o(reqAck1),
    .tx_write_o(txWrite1), .tx_data_o(txData1), .tx_busy_i(txBusy1),
    .grant_o(grant1), .grant_index_o(grantIndex1),
    .active_o(active1), .timeout_o(timeout1)
  );

  // Free-running 10-unit clock shared by both instances.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs to the four-requester instance, then advance
  // past the next rising edge so the registered outputs can be sampled.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                               input logic [31:0] data, input logic busy);
    reset    = rst;
    reqValid = valid;
    reqData  = data;
    txBusy   = busy;
    @(posedge clock);
    #1;
    if (txWrite) writeCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic checkMain(input string name, input logic [3:0] eAck,
                           input logic eWrite, input logic [7:0] eData,
                           input logic [3:0] eGrant, input logic [1:0] eIdx,
                           input logic eActive, input logic eTimeout);
    checkOutput({name, ".ack"},     32'(reqAck),     32'(eAck));
    checkOutput({name, ".write"},   32'(txWrite),    32'(eWrite));
    checkOutput({name, ".data"},    32'(txData),     32'(eData));
    checkOutput({name, ".grant"},   32'(grant),      32'(eGrant));
    checkOutput({name, ".index"},   32'(grantIndex), 32'(eIdx));
    checkOutput({name, ".active"},  32'(active),     32'(eActive));
    checkOutput({name, ".timeout"}, 32'(timeout),    32'(eTimeout));
  endtask

  initial begin
    int expOrder [6];
    checkCount = 0;
    passCount  = 0;
    writeCount = 0;
    reset      = 1'b1;
    reqValid   = '0;
    reqData    = '0;
    txBusy     = 1'b0;
    reqValid1  = 1'b0;
    reqData1   = '0;
    txBusy1    = 1'b0;

    // Per-cycle vectors: reset, a short write to requester 2, a start held
    // off by busy then released, and a wrap-around choice between 0 and 3.
    vecs[0]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0001, 32'h0000003C, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0001, 32'h0000003C, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0001, 32'h0000003C, 1'b0, 4'b0001, 1'b1, 8'h3C, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h3C, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h3C, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h3C, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b1001, 32'h77000011, 1'b0, 4'b1000, 1'b1, 8'h77, 4'b1000, 2'd3, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].busy);
      checkMain($sformatf("vec%0d", i), vecs[i].eAck, vecs[i].eWrite,
                vecs[i].eData, vecs[i].eGrant, vecs[i].eIdx,
                vecs[i].eActive, vecs[i].eTimeout);
    end

    // Exact single write: busy high during T+2..T+19, low again at T+20,
    // idle at T+21 with exactly one write pulse.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    writeCount = 0;
    applyStimulus(1'b0, 4'b0100, 32'h00A50000, 1'b0);
    checkMain("single.t1", 4'b0100, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    for (int c = 2; c <= 19; c++) applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);
    checkMain("single.t20", 4'b0000, 1'b0, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    checkMain("single.t21", 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd2, 1'b0, 1'b0);
    checkOutput("single.writes", 32'(writeCount), 32'd1);

    // Fairness: all four requesters valid the whole time.
    expOrder = '{0, 1, 2, 3, 0, 1};
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b0, 4'b1111, 32'h13121110, 1'b0);
      checkMain($sformatf("fair%0d", n), 4'(1 << expOrder[n]), 1'b1,
                8'(8'h10 + expOrder[n]), 4'(1 << expOrder[n]),
                2'(expOrder[n]), 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 32'h13121110, 1'b0);
      applyStimulus(1'b0, 4'b1111, 32'h13121110, 1'b1);
      applyStimulus(1'b0, 4'b1111, 32'h13121110, 1'b0);
      checkOutput($sformatf("fair%0d.idle", n), 32'(active), 32'd0);
    end

    // Watchdog: busy never rises. Write at W, timeout pulse at W+17,
    // pending requester 3 granted at W+18.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 32'h5A0000C3, 1'b0);
    checkMain("wdog.w", 4'b0001, 1'b1, 8'hC3, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 4'b1000, 32'h5A0000C3, 1'b0);
      checkOutput($sformatf("wdog.w%0d.timeout", k), 32'(timeout), 32'd0);
    end
    checkOutput("wdog.w16.active", 32'(active), 32'd1);
    applyStimulus(1'b0, 4'b1000, 32'h5A0000C3, 1'b0);
    checkMain("wdog.w17", 4'b0000, 1'b0, 8'hC3, 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b1000, 32'h5A0000C3, 1'b0);
    checkMain("wdog.w18", 4'b1000, 1'b1, 8'h5A, 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset while requester 2 owns the transmitter in WAIT_DONE.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 32'h00E70000, 1'b0);
    checkMain("rst.grant", 4'b0100, 1'b1, 8'hE7, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);
    checkOutput("rst.busyActive", 32'(active), 32'd1);
    applyStimulus(1'b1, 4'b0101, 32'h00E70055, 1'b1);
    checkMain("rst.cleared", 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0101, 32'h00E70055, 1'b0);
    checkMain("rst.after", 4'b0001, 1'b1, 8'h55, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Single-requester build: three bytes in order, no timeouts.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      reqValid1 = 1'b1;
      reqData1  = 8'(8'h11 * (b + 1));
      txBusy1   = 1'b0;
      applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
      checkOutput($sformatf("one%0d.ack", b),   32'(reqAck1),  32'd1);
      checkOutput($sformatf("one%0d.write", b), 32'(txWrite1), 32'd1);
      checkOutput($sformatf("one%0d.data", b),  32'(txData1),  32'(8'h11 * (b + 1)));
      checkOutput($sformatf("one%0d.grant", b), 32'(grant1),   32'd1);
      reqValid1 = 1'b0;
      applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
      txBusy1 = 1'b1;
      applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
      txBusy1 = 1'b0;
      applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
      checkOutput($sformatf("one%0d.active", b),  32'(active1),     32'd0);
      checkOutput($sformatf("one%0d.index", b),   32'(grantIndex1), 32'd0);
      checkOutput($sformatf("one%0d.timeout", b), 32'(timeout1),    32'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
